// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module   : mul_div_unit_pkg
// Brief    : Shared encodings and defaults for the iterative mul/div unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_AW    = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// Module   : muldiv_datapath
// Brief    : One iteration step: shift-add multiply or restoring-divide step.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_datapath
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic               i_op,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opa,
    input  logic [WIDTH-1:0]   i_opb,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opa} : {(WIDTH+1){1'b0}});
        w_rem_sh   = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, i_opb});
        w_diff     = w_rem_sh - {1'b0, i_opb};
        o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        if (i_op == OP_DIV) begin
            o_acc_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                          i_acc[WIDTH-2:0], w_ge};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative multiply/divide unit, one result bit per clock.
//            Define SIGNED_MULDIV_EN for two's-complement operation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int AW    = c_DEFAULT_AW,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [AW-1:0]    dest,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [AW-1:0]    wadd,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] wr0,
    output logic             regwrite,
    output logic             r0write
);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dz;
    logic [AW-1:0]        r_wadd;
    logic [WIDTH-1:0]     r_wdata;
    logic [WIDTH-1:0]     r_wr0;

    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_op       (r_op),
        .i_acc      (r_acc),
        .i_opa      (r_a),
        .i_opb      (r_b),
        .o_acc_next (w_acc_next)
    );

`ifdef SIGNED_MULDIV_EN
    logic r_neg_lo;
    logic r_neg_hi;

    assign w_mag_a = opa[WIDTH-1] ? -opa : opa;
    assign w_mag_b = opb[WIDTH-1] ? -opb : opb;

    // Product negates as a whole; quotient and remainder negate independently.
    always_comb begin
        w_res = w_acc_next;
        if (r_op == OP_MUL) begin
            if (r_neg_lo) w_res = -w_acc_next;
        end else begin
            if (r_neg_lo) w_res[WIDTH-1:0]       = -w_acc_next[WIDTH-1:0];
            if (r_neg_hi) w_res[2*WIDTH-1:WIDTH] = -w_acc_next[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_neg_lo <= opa[WIDTH-1] ^ opb[WIDTH-1];
            r_neg_hi <= opa[WIDTH-1];
        end
    end
`else
    assign w_mag_a = opa;
    assign w_mag_b = opb;
    assign w_res   = w_acc_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_wadd  <= '0;
            r_wdata <= '0;
            r_wr0   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_a    <= w_mag_a;
                        r_b    <= w_mag_b;
                        r_wadd <= dest;
                        r_busy <= 1'b1;
                        r_dz   <= 1'b0;
                        r_cnt  <= CW'(WIDTH);
                        if (op == OP_DIV && opb == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_dz    <= 1'b1;
                            r_wdata <= '1;
                            r_wr0   <= opa;
                            r_acc   <= '0;
                        end else begin
                            r_state <= ST_RUN;
                            r_acc   <= {{WIDTH{1'b0}}, (op == OP_MUL) ? w_mag_b : w_mag_a};
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_wdata <= w_res[WIDTH-1:0];
                        r_wr0   <= w_res[2*WIDTH-1:WIDTH];
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign regwrite = r_done;
    assign r0write  = r_done;
    assign dz       = r_dz;
    assign wadd     = r_wadd;
    assign wdata    = r_wdata;
    assign wr0      = r_wr0;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed self-checking bench for mul_div_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic [3:0]  dest = '0;
    logic        busy, done, dz, regwrite, r0write;
    logic [3:0]  wadd;
    logic [15:0] wdata, wr0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int n;
    int snap;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    mul_div_unit u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .dest     (dest),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .wadd     (wadd),
        .wdata    (wdata),
        .wr0      (wr0),
        .regwrite (regwrite),
        .r0write  (r0write)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation; n returns the cycle (1 = first after accept) showing done.
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d, input int pulse_at, output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; dest = d;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; opa = 16'hA5A5; opb = 16'h5A5A; dest = 4'hF;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == pulse_at) begin
                start = 1'b1; op = 1'b1; opa = 16'h0009; opb = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_after_done(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        check({tag, "_strobe_low"}, {30'd0, regwrite, r0write}, 32'd0);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset held for two cycles.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_done_dz", {29'd0, busy, done, dz}, 32'd0);
        check("rst_strobes", {30'd0, regwrite, r0write}, 32'd0);
        check("rst_results", {wdata, wr0}, 32'd0);
        check("rst_wadd", {28'd0, wadd}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 16'h1234, 16'h0010, 4'd5, 0, n);
        check("mul1_latency", n, 32'd17);
        check("mul1_result", {wr0, wdata}, 32'h0001_2340);
        check("mul1_strobes", {29'd0, regwrite, r0write, busy}, 32'd7);
        check("mul1_wadd_dz", {27'd0, wadd, dz}, {27'd0, 4'd5, 1'b0});
        check_after_done("mul1");
        check("mul1_hold", {wr0, wdata}, 32'h0001_2340);

        run_op(1'b0, 16'hFFFF, 16'hFFFF, 4'd3, 0, n);
`ifdef SIGNED_MULDIV_EN
        check("mul_ffff_result", {wr0, wdata}, 32'h0000_0001);
`else
        check("mul_ffff_result", {wr0, wdata}, 32'hFFFE_0001);
`endif
        check_after_done("mul2");

        run_op(1'b1, 16'd100, 16'd7, 4'd9, 0, n);
        check("div_latency", n, 32'd17);
        check("div_result", {wr0, wdata}, 32'h0002_000E);
        check("div_dz", {31'd0, dz}, 32'd0);
        check("div_wadd", {28'd0, wadd}, 32'd9);
        check_after_done("div");

        run_op(1'b1, 16'h00FF, 16'h0000, 4'd4, 0, n);
        check("dz_latency", n, 32'd1);
        check("dz_result", {wr0, wdata}, 32'h00FF_FFFF);
        check("dz_flag_strobes", {29'd0, dz, regwrite, r0write}, 32'd7);
        check_after_done("dz");
        check("dz_hold", {31'd0, dz}, 32'd1);

        // Start pulse during RUN must be ignored.
        run_op(1'b0, 16'h0003, 16'h0005, 4'd2, 5, n);
        check("ign_latency", n, 32'd17);
        check("ign_result", {wr0, wdata}, 32'h0000_000F);
        check("ign_dz_wadd", {27'd0, wadd, dz}, {27'd0, 4'd2, 1'b0});
        check_after_done("ign");

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 16'h00FF; opb = 16'h0101; dest = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        snap = done_cnt;
        reset = 1'b0;
        #1;
        check("midrst_busy_done_dz", {29'd0, busy, done, dz}, 32'd0);
        check("midrst_outputs", {wdata, wr0}, 32'd0);
        check("midrst_wadd", {28'd0, wadd}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt - snap, 32'd0);

        run_op(1'b1, 16'd1000, 16'd33, 4'd6, 0, n);
        check("post_rst_latency", n, 32'd17);
        check("post_rst_result", {wr0, wdata}, 32'h000A_001E);
        check_after_done("post_rst");

`ifdef SIGNED_MULDIV_EN
        run_op(1'b1, 16'hFFF9, 16'h0002, 4'd1, 0, n);
        check("sdiv_latency", n, 32'd17);
        check("sdiv_result", {wr0, wdata}, 32'hFFFF_FFFD);
        check_after_done("sdiv");
        run_op(1'b0, 16'hFFFF, 16'h0002, 4'd1, 0, n);
        check("smul_result", {wr0, wdata}, 32'hFFFF_FFFE);
        check_after_done("smul");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
